mips_multicycle_core: RTL and testbench
=======================================

# mips_multicycle_core

Parametrised multi-cycle MIPS-subset processor. It is the next generation of the single-cycle datapath. It executes one instruction in 3–5 clock cycles through an explicit FSM (fetch, decode, execute, memory, write-back), which removes the combinational `always @(pc)` write-back hazard. Data width, register-file depth and PC width are parameters. The block adds start/halt control, branches, jumps, stores and an illegal-opcode flag. It sits between the instruction ROM and data RAM as the top-level compute core.

## Interface
- `DATA_W`, 32: datapath and register width (≥16).
- `REG_COUNT`, 8: general registers; power of two, 2..32. Register index = low log2(`REG_COUNT`) bits of the rs/rt/rd fields.
- `PC_W`, 16: PC width; byte address, word aligned.

- `clock` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; leaves IDLE when sampled high.
- `i_addr` out `PC_W`: instruction address (= PC).
- `i_datain` in 32: instruction word; combinational ROM, valid in the same cycle as `i_addr`.
- `d_addr` out `DATA_W`: data address (ALU result).
- `d_dataout` out `DATA_W`: store data (rt value).
- `d_we` out 1: data write strobe, one cycle per sw.
- `d_datain` in `DATA_W`: load data; combinational RAM, valid in the same cycle as `d_addr`.
- `busy` out 1: high in every state except IDLE and HALT.
- `halted` out 1: high in HALT.
- `illegal` out 1: one-cycle pulse on an unsupported opcode/funct.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Reset behaviour: PC = 0, all registers = 0, state = IDLE, IR = 0. All outputs are 0 during and after reset.
- IDLE → FETCH when `start` = 1.
- FETCH: IR ← `i_datain`; PC ← PC + 4 (wraps modulo 2^`PC_W`).
- DECODE:
  - A ← gr[rs], B ← gr[rt].
  - imm ← sign-extended instr[15:0] to `DATA_W`.
  - IR = 32'hFFFF_FFFF → HALT.
- EXEC by instruction:
  - R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x26 xor, 0x2A slt (signed, result 0/1).
  - addi (op 0x08): A + imm.
  - lw (0x23) / sw (0x2B): address = A + imm.
  - beq (0x04): if A == B, PC ← PC + (imm<<2) using the already-incremented PC, truncated to `PC_W`; next state FETCH.
  - j (0x02): PC ← {PC[`PC_W`-1:28] if `PC_W` > 28, instr[25:0]<<2} truncated to `PC_W`; next state FETCH.
  - Unsupported opcode/funct: `illegal` = 1 for this cycle; no state change; next state FETCH.
  - Arithmetic wraps modulo 2^`DATA_W`; no overflow trap.
- MEM:
  - lw: MDR ← `d_datain`; next state WB.
  - sw: `d_we` = 1, `d_addr` = ALU result, `d_dataout` = B; next state FETCH.
- WB:
  - R-type writes gr[rd]; addi and lw write gr[rt].
  - Writes to index 0 are discarded; gr[0] always reads 0.
  - Next state FETCH.
- HALT: sticky until reset. `start` is ignored.
- `d_addr` and `d_dataout` are driven only in MEM. They are 0 in all other states.

## Timing
- Cycles per instruction: beq/j/illegal 3; R-type/addi/sw 4; lw 5.
- Register file writes at the rising edge that ends WB. A following instruction's DECODE sees the new value; there is no bypass need.
- `d_we` is high for exactly the MEM cycle of a sw. It is never high for lw.
- `start` deasserted mid-program has no effect; only IDLE samples it.
- `rst_n` low in any state aborts the instruction immediately. Any pending write is lost. `d_we` drops asynchronously.
- `halted` rises in the cycle after DECODE of 32'hFFFF_FFFF.

## Test plan
- Reset/idle: hold `rst_n` = 0, then release with `start` = 0 for 10 cycles → `i_addr` = 0, `busy` = 0, `d_we` = 0 throughout.
- ALU ops:
  - Program: addi r1,r0,5; addi r2,r0,-3; add r3,r1,r2; sub r4,r2,r1; slt r5,r2,r1; halt.
  - Required: r3 = 2, r4 = 0xFFFF_FFF8, r5 = 1.
  - `halted` is asserted exactly 4+4+4+4+4+3 cycles after `start`.
- Memory:
  - sw r1,8(r0) with r1 = 0x1234 → one `d_we` pulse with `d_addr` = 8, `d_dataout` = 0x1234.
  - lw r6,8(r0) with RAM returning 0x1234 → r6 = 0x1234 after 5 cycles.
- Control flow:
  - beq r0,r0,-1 at PC 0x10 → PC returns to 0x10.
  - beq with unequal operands → PC advances to 0x14.
  - j 0x40 → `i_addr` = 0x100 at the next FETCH.
- Illegal and r0:
  - Opcode 0x3F → single `illegal` pulse, no register change, PC + 4.
  - add r0,r1,r1 → gr[0] still reads 0.
- Parameters and mid-instruction reset:
  - `DATA_W` = 16, `REG_COUNT` = 4: addi r3,r0,0x7FFF then add r3,r3,r3 → r3 = 0xFFFE.
  - `rst_n` pulsed during a lw's MEM state → no write occurs and all registers read 0.

Source files
------------

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS-subset core: fetch/decode/execute/memory/write-back FSM with start/halt
// control, beq/j, lw/sw and an illegal-instruction pulse.
module mips_multicycle_core #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned REG_COUNT = 8,
   parameter int unsigned PC_W      = 16
) (
   input  logic              clock,
   input  logic              rst_n,
   input  logic              start,
   output logic [PC_W-1:0]   i_addr,
   input  logic [31:0]       i_datain,
   output logic [DATA_W-1:0] d_addr,
   output logic [DATA_W-1:0] d_dataout,
   output logic              d_we,
   input  logic [DATA_W-1:0] d_datain,
   output logic              busy,
   output logic              halted,
   output logic              illegal
);
   localparam int unsigned IDX_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

   localparam logic [5:0] OpR    = 6'h00;
   localparam logic [5:0] OpJ    = 6'h02;
   localparam logic [5:0] OpBeq  = 6'h04;
   localparam logic [5:0] OpAddi = 6'h08;
   localparam logic [5:0] OpLw   = 6'h23;
   localparam logic [5:0] OpSw   = 6'h2B;
   localparam logic [5:0] FnAdd  = 6'h20;
   localparam logic [5:0] FnSub  = 6'h22;
   localparam logic [5:0] FnAnd  = 6'h24;
   localparam logic [5:0] FnOr   = 6'h25;
   localparam logic [5:0] FnXor  = 6'h26;
   localparam logic [5:0] FnSlt  = 6'h2A;

   typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

   state_e              state_q;
   logic [PC_W-1:0]     pc_q;
   logic [31:0]         ir_q;
   logic [DATA_W-1:0]   a_q, b_q, imm_q, alu_q, mdr_q;
   logic [DATA_W-1:0]   gr_q [REG_COUNT];
   logic [DATA_W-1:0]   d_addr_q, d_dataout_q;
   logic                d_we_q, busy_q, halted_q, illegal_q;

   logic [5:0]          op, funct;
   logic [IDX_W-1:0]    rs_idx, rt_idx, rd_idx, wb_idx;
   logic                legal;
   logic [DATA_W-1:0]   alu_res;
   logic [PC_W-1:0]     br_off, br_tgt, j_tgt;

   always_comb begin
      op      = ir_q[31:26];
      funct   = ir_q[5:0];
      rs_idx  = ir_q[21 +: IDX_W];
      rt_idx  = ir_q[16 +: IDX_W];
      rd_idx  = ir_q[11 +: IDX_W];
      wb_idx  = (op == OpR) ? rd_idx : rt_idx;
      legal   = (op == OpR) ? (funct inside {FnAdd, FnSub, FnAnd, FnOr, FnXor, FnSlt})
                            : (op inside {OpAddi, OpLw, OpSw, OpBeq, OpJ});
      alu_res = a_q + imm_q;
      if (op == OpR) begin
         case (funct)
            FnAdd:   alu_res = a_q + b_q;
            FnSub:   alu_res = a_q - b_q;
            FnAnd:   alu_res = a_q & b_q;
            FnOr:    alu_res = a_q | b_q;
            FnXor:   alu_res = a_q ^ b_q;
            FnSlt:   alu_res = DATA_W'($signed(a_q) < $signed(b_q));
            default: alu_res = '0;
         endcase
      end
      // Branch offset is relative to the already-incremented PC.
      br_off = PC_W'($signed(imm_q));
      br_tgt = pc_q + (br_off << 2);
      j_tgt  = (pc_q & ~PC_W'(28'hFFF_FFFF)) | PC_W'({ir_q[25:0], 2'b00});
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         pc_q        <= '0;
         ir_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         imm_q       <= '0;
         alu_q       <= '0;
         mdr_q       <= '0;
         d_addr_q    <= '0;
         d_dataout_q <= '0;
         d_we_q      <= 1'b0;
         busy_q      <= 1'b0;
         halted_q    <= 1'b0;
         illegal_q   <= 1'b0;
         for (int i = 0; i < int'(REG_COUNT); i++) gr_q[i] <= '0;
      end else begin
         illegal_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q <= StFetch;
                  busy_q  <= 1'b1;
               end
            end
            StFetch: begin
               ir_q    <= i_datain;
               pc_q    <= pc_q + PC_W'(4);
               state_q <= StDecode;
            end
            StDecode: begin
               a_q   <= gr_q[rs_idx];
               b_q   <= gr_q[rt_idx];
               imm_q <= DATA_W'($signed(ir_q[15:0]));
               if (ir_q == 32'hFFFF_FFFF) begin
                  state_q  <= StHalt;
                  busy_q   <= 1'b0;
                  halted_q <= 1'b1;
               end else begin
                  state_q   <= StExec;
                  illegal_q <= ~legal;
               end
            end
            StExec: begin
               state_q <= StFetch;
               if (legal) begin
                  case (op)
                     OpR, OpAddi: begin
                        alu_q   <= alu_res;
                        state_q <= StWb;
                     end
                     OpLw: begin
                        d_addr_q <= alu_res;
                        state_q  <= StMem;
                     end
                     OpSw: begin
                        d_addr_q    <= alu_res;
                        d_dataout_q <= b_q;
                        d_we_q      <= 1'b1;
                        state_q     <= StMem;
                     end
                     OpBeq:   if (a_q == b_q) pc_q <= br_tgt;
                     OpJ:     pc_q <= j_tgt;
                     default: ;
                  endcase
               end
            end
            StMem: begin
               d_addr_q    <= '0;
               d_dataout_q <= '0;
               d_we_q      <= 1'b0;
               if (op == OpLw) begin
                  mdr_q   <= d_datain;
                  state_q <= StWb;
               end else begin
                  state_q <= StFetch;
               end
            end
            StWb: begin
               // gr_q[0] is never written, so it always reads zero.
               if (wb_idx != '0) gr_q[wb_idx] <= (op == OpLw) ? mdr_q : alu_q;
               state_q <= StFetch;
            end
            StHalt:  state_q <= StHalt;
            default: state_q <= StIdle;
         endcase
      end
   end

   assign i_addr    = pc_q;
   assign d_addr    = d_addr_q;
   assign d_dataout = d_dataout_q;
   assign d_we      = d_we_q;
   assign busy      = busy_q;
   assign halted    = halted_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Bench for mips_multicycle_core: 32-bit and 16-bit instances run the same programs and are
// checked against an instruction-level reference model (stores, illegal pulses, halt time).
module tb_mips_multicycle_core;
   logic clock = 1'b0;
   logic rst_n, start;
   always #5 clock = ~clock;

   logic [15:0] i_addr32, i_addr16;
   logic [31:0] i_data32, i_data16;
   logic [31:0] d_addr32, d_dout32, d_din32;
   logic [15:0] d_addr16, d_dout16, d_din16;
   logic        d_we32, busy32, halted32, ill32;
   logic        d_we16, busy16, halted16, ill16;

   logic [31:0] rom [256];
   logic [31:0] ram_init [64];
   logic [31:0] ram32 [64];
   logic [31:0] ram16 [64];

   assign i_data32 = rom[i_addr32[9:2]];
   assign i_data16 = rom[i_addr16[9:2]];
   assign d_din32  = ram32[d_addr32[7:2]];
   assign d_din16  = ram16[d_addr16[7:2]][15:0];

   mips_multicycle_core u_dut32 (
      .clock(clock), .rst_n(rst_n), .start(start), .i_addr(i_addr32), .i_datain(i_data32),
      .d_addr(d_addr32), .d_dataout(d_dout32), .d_we(d_we32), .d_datain(d_din32),
      .busy(busy32), .halted(halted32), .illegal(ill32));

   mips_multicycle_core #(.DATA_W(16), .REG_COUNT(4), .PC_W(16)) u_dut16 (
      .clock(clock), .rst_n(rst_n), .start(start), .i_addr(i_addr16), .i_datain(i_data16),
      .d_addr(d_addr16), .d_dataout(d_dout16), .d_we(d_we16), .d_datain(d_din16),
      .busy(busy16), .halted(halted16), .illegal(ill16));

   int n_cmp = 0, n_bad = 0;
   int hc32, hc16, ic32, ic16, exp_cyc, exp_ill;
   logic [31:0] obs32_a[$], obs32_d[$], obs16_a[$], obs16_d[$], exp_a[$], exp_d[$];
   logic [15:0] iatr [64];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc_r(input int f, input int rd, input int rs, input int rt);
      return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, 6'(f)};
   endfunction
   function automatic logic [31:0] enc_i(input int op, input int rt, input int rs,
                                         input logic [15:0] imm);
      return {6'(op), 5'(rs), 5'(rt), imm};
   endfunction
   function automatic logic [31:0] sx(input logic [31:0] v, input int dw);
      return (dw == 32) ? v : {{16{v[15]}}, v[15:0]};
   endfunction

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) rom[i] = 32'hFFFF_FFFF;
      for (int i = 0; i < 64; i++) ram_init[i] = '0;
   endtask

   // Store r1..r7 to 0x80.. and halt, starting at word index base.
   task automatic load_dump(input int base);
      for (int i = 1; i < 8; i++) rom[base+i-1] = enc_i('h2B, i, 0, 16'(32'h80 + 4 * (i - 1)));
      rom[base+7] = 32'hFFFF_FFFF;
   endtask

   // Instruction-level reference: ISA semantics plus per-class cycle cost.
   task automatic model_run(input int dw, input int nreg);
      logic [31:0] m, pc, ir, a, b, imm, res, ea;
      logic [31:0] regs [32];
      logic [31:0] mram [64];
      int rs, rt, rd, op, fn, wi;
      bit wr;
      m = (dw == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
      exp_a.delete(); exp_d.delete();
      exp_cyc = 0; exp_ill = 0; pc = 0;
      for (int i = 0; i < 32; i++) regs[i] = '0;
      for (int i = 0; i < 64; i++) mram[i] = ram_init[i];
      for (int step = 0; step < 500; step++) begin
         ir = rom[pc[9:2]];
         pc = (pc + 4) & 32'hFFFF;
         if (ir == 32'hFFFF_FFFF) begin exp_cyc += 3; break; end
         op = int'(ir[31:26]); fn = int'(ir[5:0]);
         rs = int'(ir[25:21]) % nreg; rt = int'(ir[20:16]) % nreg; rd = int'(ir[15:11]) % nreg;
         a = regs[rs]; b = regs[rt];
         imm = {{16{ir[15]}}, ir[15:0]} & m;
         ea = (a + imm) & m;
         wr = 0; wi = rt; res = 0;
         case (op)
            0: begin
               wr = 1; wi = rd;
               case (fn)
                  'h20: res = a + b;
                  'h22: res = a - b;
                  'h24: res = a & b;
                  'h25: res = a | b;
                  'h26: res = a ^ b;
                  'h2A: res = ($signed(sx(a, dw)) < $signed(sx(b, dw))) ? 32'd1 : 32'd0;
                  default: begin wr = 0; exp_ill++; end
               endcase
               exp_cyc += wr ? 4 : 3;
            end
            'h08: begin res = a + imm; wr = 1; exp_cyc += 4; end
            'h23: begin res = mram[(ea >> 2) & 63]; wr = 1; exp_cyc += 5; end
            'h2B: begin
               exp_a.push_back(ea); exp_d.push_back(b);
               mram[(ea >> 2) & 63] = b; exp_cyc += 4;
            end
            'h04: begin if (a == b) pc = (pc + (imm << 2)) & 32'hFFFF; exp_cyc += 3; end
            'h02: begin pc = {4'h0, ir[25:0], 2'b00} & 32'hFFFF; exp_cyc += 3; end
            default: begin exp_ill++; exp_cyc += 3; end
         endcase
         if (wr && wi != 0) regs[wi] = res & m;
      end
   endtask

   task automatic run_prog(input bit do_reset, input int limit);
      if (do_reset) begin
         @(negedge clock); rst_n = 1'b0;
         @(negedge clock); rst_n = 1'b1;
      end
      for (int i = 0; i < 64; i++) begin ram32[i] = ram_init[i]; ram16[i] = ram_init[i]; end
      obs32_a.delete(); obs32_d.delete(); obs16_a.delete(); obs16_d.delete();
      hc32 = 0; hc16 = 0; ic32 = 0; ic16 = 0;
      start = 1'b1;
      for (int c = 1; c <= limit; c++) begin
         @(posedge clock); #1;
         if (c == 2) start = 1'b0;
         if (c < 64) iatr[c] = i_addr32;
         if (d_we32) begin
            obs32_a.push_back(d_addr32); obs32_d.push_back(d_dout32);
            ram32[d_addr32[7:2]] = d_dout32;
         end
         if (d_we16) begin
            obs16_a.push_back({16'h0, d_addr16}); obs16_d.push_back({16'h0, d_dout16});
            ram16[d_addr16[7:2]] = {16'h0, d_dout16};
         end
         if (ill32) ic32++;
         if (ill16) ic16++;
         if (halted32 && hc32 == 0) hc32 = c;
         if (halted16 && hc16 == 0) hc16 = c;
         if (hc32 != 0 && hc16 != 0) break;
      end
      start = 1'b0;
   endtask

   task automatic check_dut(input string tag, input bit w16);
      int n;
      model_run(w16 ? 16 : 32, w16 ? 4 : 8);
      chk({tag, w16 ? "/16:halt_cycles" : "/32:halt_cycles"}, 32'(w16 ? hc16 : hc32),
          32'(exp_cyc));
      chk({tag, w16 ? "/16:illegal_pulses" : "/32:illegal_pulses"}, 32'(w16 ? ic16 : ic32),
          32'(exp_ill));
      n = w16 ? obs16_d.size() : obs32_d.size();
      chk({tag, w16 ? "/16:store_count" : "/32:store_count"}, 32'(n), 32'(exp_d.size()));
      for (int i = 0; i < n && i < exp_d.size(); i++) begin
         chk($sformatf("%s/%0d:store%0d_addr", tag, w16 ? 16 : 32, i),
             w16 ? obs16_a[i] : obs32_a[i], exp_a[i]);
         chk($sformatf("%s/%0d:store%0d_data", tag, w16 ? 16 : 32, i),
             w16 ? obs16_d[i] : obs32_d[i], exp_d[i]);
      end
   endtask

   initial begin
      bit found;
      rst_n = 1'b0; start = 1'b0;
      clear_prog();
      for (int i = 0; i < 64; i++) begin ram32[i] = '0; ram16[i] = '0; end

      // Reset and idle
      @(posedge clock); #1;
      chk("reset:i_addr", {16'h0, i_addr32}, 0);
      chk("reset:busy", {31'h0, busy32}, 0);
      chk("reset:halted", {31'h0, halted32}, 0);
      chk("reset:illegal", {31'h0, ill32}, 0);
      chk("reset:d_we", {31'h0, d_we32}, 0);
      chk("reset:d_addr", d_addr32, 0);
      chk("reset:d_dataout", d_dout32, 0);
      chk("reset:busy16", {31'h0, busy16}, 0);
      @(negedge clock); rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clock); #1;
         chk("idle:i_addr", {16'h0, i_addr32}, 0);
         chk("idle:busy", {31'h0, busy32}, 0);
         chk("idle:d_we", {31'h0, d_we32}, 0);
      end

      // ALU ops, halt timing
      clear_prog();
      rom[0] = enc_i('h08, 1, 0, 16'd5);
      rom[1] = enc_i('h08, 2, 0, 16'hFFFD);
      rom[2] = enc_r('h20, 3, 1, 2);
      rom[3] = enc_r('h22, 4, 2, 1);
      rom[4] = enc_r('h2A, 5, 2, 1);
      run_prog(1, 200);
      chk("alu:halt_at", 32'(hc32), 32'(4 + 4 + 4 + 4 + 4 + 3));
      check_dut("alu", 0); check_dut("alu", 1);
      rom[5] = enc_i('h2B, 3, 0, 16'h40);
      rom[6] = enc_i('h2B, 4, 0, 16'h44);
      rom[7] = enc_i('h2B, 5, 0, 16'h48);
      run_prog(1, 200);
      chk("alu:r3", obs32_d[0], 32'd2);
      chk("alu:r4", obs32_d[1], 32'hFFFF_FFF8);
      chk("alu:r5", obs32_d[2], 32'd1);
      check_dut("alu_st", 0); check_dut("alu_st", 1);

      // Memory: sw then lw of the same word
      clear_prog();
      rom[0] = enc_i('h08, 1, 0, 16'h1234);
      rom[1] = enc_i('h2B, 1, 0, 16'd8);
      rom[2] = enc_i('h23, 6, 0, 16'd8);
      rom[3] = enc_i('h2B, 6, 0, 16'd12);
      run_prog(1, 200);
      chk("mem:sw_addr", obs32_a[0], 32'd8);
      chk("mem:sw_data", obs32_d[0], 32'h1234);
      chk("mem:lw_r6", obs32_d[1], 32'h1234);
      chk("mem:halt_at", 32'(hc32), 32'(4 + 4 + 5 + 4 + 3));
      check_dut("mem", 0); check_dut("mem", 1);

      // Control flow: taken beq, untaken beq, j
      clear_prog();
      rom[0] = enc_i('h04, 0, 0, 16'd1);
      rom[1] = enc_i('h08, 1, 0, 16'd1);
      rom[2] = enc_i('h08, 2, 0, 16'd2);
      rom[3] = enc_i('h04, 2, 1, 16'd1);
      rom[4] = enc_i('h08, 3, 0, 16'd3);
      rom[5] = {6'h02, 26'h40};
      rom[6] = enc_i('h08, 4, 0, 16'd4);
      for (int i = 1; i < 5; i++) rom[63+i] = enc_i('h2B, i, 0, 16'(32'h3C + 4 * i));
      run_prog(1, 200);
      chk("ctl:beq_untaken_pc", {16'h0, iatr[11]}, 32'h10);
      chk("ctl:pre_j_pc", {16'h0, iatr[15]}, 32'h14);
      chk("ctl:j_target_pc", {16'h0, iatr[18]}, 32'h100);
      check_dut("ctl", 0); check_dut("ctl", 1);

      // beq r0,r0,-1 at 0x10 loops back to itself
      clear_prog();
      for (int i = 0; i < 4; i++) rom[i] = enc_i('h08, 0, 0, 16'd0);
      rom[4] = enc_i('h04, 0, 0, 16'hFFFF);
      run_prog(1, 30);
      chk("loop:fetch0", {16'h0, iatr[1 + 16]}, 32'h10);
      chk("loop:incr", {16'h0, iatr[18]}, 32'h14);
      chk("loop:back1", {16'h0, iatr[1 + 16 + 3]}, 32'h10);
      chk("loop:back2", {16'h0, iatr[1 + 16 + 6]}, 32'h10);
      chk("loop:not_halted", {31'h0, halted32}, 0);

      // Illegal opcode / funct and r0 writes
      clear_prog();
      rom[0] = enc_i('h08, 1, 0, 16'd9);
      rom[1] = {6'h3F, 26'h0123456};
      rom[2] = enc_r('h20, 0, 1, 1);
      rom[3] = enc_r('h21, 2, 1, 1);
      rom[4] = enc_i('h2B, 0, 0, 16'h20);
      rom[5] = enc_i('h2B, 1, 0, 16'h24);
      rom[6] = enc_i('h2B, 2, 0, 16'h28);
      run_prog(1, 200);
      chk("ill:pulses", 32'(ic32), 32'd2);
      chk("ill:r0", obs32_d[0], 32'd0);
      chk("ill:r1", obs32_d[1], 32'd9);
      chk("ill:r2", obs32_d[2], 32'd0);
      check_dut("ill", 0); check_dut("ill", 1);

      // Width wrap: 0x7FFF + 0x7FFF
      clear_prog();
      rom[0] = enc_i('h08, 3, 0, 16'h7FFF);
      rom[1] = enc_r('h20, 3, 3, 3);
      rom[2] = enc_i('h2B, 3, 0, 16'h30);
      run_prog(1, 200);
      chk("w16:r3", obs16_d[0], 32'hFFFE);
      chk("w32:r3", obs32_d[0], 32'hFFFE);
      check_dut("wrap", 0); check_dut("wrap", 1);

      // Randomized programs followed by a register dump
      for (int it = 0; it < 6; it++) begin
         clear_prog();
         for (int i = 0; i < 64; i++) ram_init[i] = $urandom;
         for (int i = 0; i < 12; i++) begin
            case ($urandom_range(0, 9))
               0, 1, 2: rom[i] = enc_i('h08, $urandom_range(1, 7), $urandom_range(0, 7),
                                       16'($urandom));
               3, 4, 5: begin
                  int fns [6] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h2A};
                  rom[i] = enc_r(fns[$urandom_range(0, 5)], $urandom_range(0, 7),
                                 $urandom_range(0, 7), $urandom_range(0, 7));
               end
               6: rom[i] = enc_i('h2B, $urandom_range(0, 7), 0, 16'($urandom_range(0, 63) * 4));
               7: rom[i] = enc_i('h23, $urandom_range(0, 7), 0, 16'($urandom_range(0, 63) * 4));
               8: rom[i] = enc_i('h04, $urandom_range(0, 7), $urandom_range(0, 7),
                                 16'($urandom_range(0, 2)));
               default: rom[i] = $urandom_range(0, 1) ? {6'h3F, 26'($urandom)}
                                                      : enc_r('h21, 1, 2, 3);
            endcase
         end
         load_dump(12);
         run_prog(1, 400);
         check_dut($sformatf("rand%0d", it), 0);
         check_dut($sformatf("rand%0d", it), 1);
      end

      // Reset during a lw's MEM state
      clear_prog();
      ram_init[2] = 32'h1234;
      rom[0] = enc_i('h08, 1, 0, 16'h55);
      rom[1] = enc_i('h2B, 1, 0, 16'd4);
      rom[2] = enc_i('h23, 6, 0, 16'd8);
      @(negedge clock); rst_n = 1'b0;
      @(negedge clock); rst_n = 1'b1;
      for (int i = 0; i < 64; i++) begin ram32[i] = ram_init[i]; ram16[i] = ram_init[i]; end
      start = 1'b1;
      found = 1'b0;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clock); #1;
         if (c == 2) start = 1'b0;
         if (busy32 && !d_we32 && d_addr32 == 32'd8) begin found = 1'b1; break; end
      end
      chk("midrst:lw_mem_seen", {31'h0, found}, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst:d_we", {31'h0, d_we32}, 0);
      chk("midrst:busy", {31'h0, busy32}, 0);
      chk("midrst:d_addr", d_addr32, 0);
      chk("midrst:i_addr", {16'h0, i_addr32}, 0);
      chk("midrst:busy16", {31'h0, busy16}, 0);
      @(negedge clock); rst_n = 1'b1;
      clear_prog();
      load_dump(0);
      run_prog(0, 200);
      chk("midrst:r1", obs32_d[0], 32'd0);
      chk("midrst:r6", obs32_d[5], 32'd0);
      check_dut("midrst", 0); check_dut("midrst", 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
